// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM port arbiter: FSM states, owner encoding and
// default burst length.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StDone
    } arb_state_e;

    typedef enum logic [1:0] {
        OwnNone,
        OwnVga,
        OwnDma,
        OwnCpu
    } owner_e;

    localparam int unsigned BurstDefault = 4;

endpackage

// File: rtl/sdram_arb_pick.sv
// Combinational fixed-priority picker: VGA, starved CPU, DMA, CPU.
module sdram_arb_pick
    import sdram_arb_pkg::*;
(
    input  logic       vga_req_i,
    input  logic       dma_req_i,
    input  logic       cpu_req_i,
    input  logic       starve_hit_i,
    output logic [1:0] owner_o
);

    owner_e pick;

    always_comb begin
        pick = OwnNone;
        if (vga_req_i) begin
            pick = OwnVga;
        end else if (cpu_req_i && starve_hit_i) begin
            pick = OwnCpu;
        end else if (dma_req_i) begin
            pick = OwnDma;
        end else if (cpu_req_i) begin
            pick = OwnCpu;
        end
    end

    assign owner_o = pick;

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares the SDRAM controller request port between VGA, DMA and CPU masters,
// sequencing each transaction and steering read data back to its owner.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 24,
    parameter int unsigned BURST      = BurstDefault,
    parameter int unsigned CPU_STARVE = 2
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_ack,
    output logic              vga_fill,

    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_addr,
    output logic              dma_ack,
    output logic              dma_fill,

    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_wr,
    input  logic [15:0]       cpu_wdata,
    input  logic [1:0]        cpu_bytesel,
    output logic              cpu_ack,
    output logic [15:0]       cpu_rdata,

    output logic              sd_req,
    output logic [ADDR_W-1:0] sd_addr,
    output logic              sd_wr,
    output logic [15:0]       sd_wdata,
    output logic [1:0]        sd_bytesel,
    output logic              sd_burst,
    input  logic              sd_ack,
    input  logic              sd_rdvalid,
    input  logic [15:0]       sd_rdata
);

    localparam int unsigned CntW    = $clog2(BURST + 1);
    localparam int unsigned StarveW = (CPU_STARVE < 1) ? 1 : $clog2(CPU_STARVE + 1);
    localparam logic [CntW-1:0]    BurstLast = CntW'(BURST - 1);
    localparam logic [StarveW-1:0] StarveMax = StarveW'(CPU_STARVE);

    arb_state_e          state_q, state_d;
    owner_e              owner_q, owner_d;
    logic [StarveW-1:0]  starve_q, starve_d;
    logic [CntW-1:0]     word_cnt_q, word_cnt_d;

    logic                sd_req_q, sd_req_d;
    logic [ADDR_W-1:0]   sd_addr_q, sd_addr_d;
    logic                sd_wr_q, sd_wr_d;
    logic [15:0]         sd_wdata_q, sd_wdata_d;
    logic [1:0]          sd_bytesel_q, sd_bytesel_d;
    logic                sd_burst_q, sd_burst_d;

    logic                vga_ack_q, vga_ack_d;
    logic                dma_ack_q, dma_ack_d;
    logic                cpu_ack_q, cpu_ack_d;
    logic [15:0]         cpu_rdata_q, cpu_rdata_d;

    logic [1:0]          pick_code;
    owner_e              pick_owner;
    logic                starve_hit;
    logic                last_word;

    assign starve_hit = (starve_q == StarveMax);
    assign pick_owner = owner_e'(pick_code);
    // CPU reads are single words; bursts end on the BURST-th word.
    assign last_word  = (owner_q == OwnCpu) || (word_cnt_q == BurstLast);

    sdram_arb_pick u_pick (
        .vga_req_i    (vga_req),
        .dma_req_i    (dma_req),
        .cpu_req_i    (cpu_req),
        .starve_hit_i (starve_hit),
        .owner_o      (pick_code)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        starve_d     = starve_q;
        word_cnt_d   = word_cnt_q;
        sd_req_d     = sd_req_q;
        sd_addr_d    = sd_addr_q;
        sd_wr_d      = sd_wr_q;
        sd_wdata_d   = sd_wdata_q;
        sd_bytesel_d = sd_bytesel_q;
        sd_burst_d   = sd_burst_q;
        vga_ack_d    = 1'b0;
        dma_ack_d    = 1'b0;
        cpu_ack_d    = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (!cpu_req) begin
                    starve_d = '0;
                end
                case (pick_owner)
                    OwnVga: begin
                        sd_addr_d    = vga_addr;
                        sd_wr_d      = 1'b0;
                        sd_wdata_d   = '0;
                        sd_bytesel_d = 2'b11;
                        sd_burst_d   = 1'b1;
                    end
                    OwnDma: begin
                        sd_addr_d    = dma_addr;
                        sd_wr_d      = 1'b0;
                        sd_wdata_d   = '0;
                        sd_bytesel_d = 2'b11;
                        sd_burst_d   = 1'b1;
                        if (cpu_req && !starve_hit) begin
                            starve_d = starve_q + 1'b1;
                        end
                    end
                    OwnCpu: begin
                        sd_addr_d    = cpu_addr;
                        sd_wr_d      = cpu_wr;
                        sd_wdata_d   = cpu_wdata;
                        sd_bytesel_d = cpu_bytesel;
                        sd_burst_d   = 1'b0;
                        starve_d     = '0;
                    end
                    default: ;
                endcase
                if (pick_owner != OwnNone) begin
                    owner_d  = pick_owner;
                    sd_req_d = 1'b1;
                    state_d  = StReq;
                end
            end

            StReq: begin
                if (sd_ack) begin
                    sd_req_d   = 1'b0;
                    word_cnt_d = '0;
                    if (sd_wr_q) begin
                        state_d   = StDone;
                        vga_ack_d = (owner_q == OwnVga);
                        dma_ack_d = (owner_q == OwnDma);
                        cpu_ack_d = (owner_q == OwnCpu);
                    end else begin
                        state_d = StWait;
                    end
                end
            end

            StWait: begin
                if (sd_rdvalid) begin
                    word_cnt_d = word_cnt_q + 1'b1;
                    if (owner_q == OwnCpu) begin
                        cpu_rdata_d = sd_rdata;
                    end
                    if (last_word) begin
                        state_d   = StDone;
                        vga_ack_d = (owner_q == OwnVga);
                        dma_ack_d = (owner_q == OwnDma);
                        cpu_ack_d = (owner_q == OwnCpu);
                    end
                end
            end

            StDone: begin
                state_d = StIdle;
                owner_d = OwnNone;
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            owner_q      <= OwnNone;
            starve_q     <= '0;
            word_cnt_q   <= '0;
            sd_req_q     <= 1'b0;
            sd_addr_q    <= '0;
            sd_wr_q      <= 1'b0;
            sd_wdata_q   <= '0;
            sd_bytesel_q <= '0;
            sd_burst_q   <= 1'b0;
            vga_ack_q    <= 1'b0;
            dma_ack_q    <= 1'b0;
            cpu_ack_q    <= 1'b0;
            cpu_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            starve_q     <= starve_d;
            word_cnt_q   <= word_cnt_d;
            sd_req_q     <= sd_req_d;
            sd_addr_q    <= sd_addr_d;
            sd_wr_q      <= sd_wr_d;
            sd_wdata_q   <= sd_wdata_d;
            sd_bytesel_q <= sd_bytesel_d;
            sd_burst_q   <= sd_burst_d;
            vga_ack_q    <= vga_ack_d;
            dma_ack_q    <= dma_ack_d;
            cpu_ack_q    <= cpu_ack_d;
            cpu_rdata_q  <= cpu_rdata_d;
        end
    end

    assign sd_req     = sd_req_q;
    assign sd_addr    = sd_addr_q;
    assign sd_wr      = sd_wr_q;
    assign sd_wdata   = sd_wdata_q;
    assign sd_bytesel = sd_bytesel_q;
    assign sd_burst   = sd_burst_q;
    assign vga_ack    = vga_ack_q;
    assign dma_ack    = dma_ack_q;
    assign cpu_ack    = cpu_ack_q;
    assign cpu_rdata  = cpu_rdata_q;

    // Fill strobes are same-cycle pass-throughs of the controller's data valid.
    assign vga_fill = (state_q == StWait) && (owner_q == OwnVga) && sd_rdvalid;
    assign dma_fill = (state_q == StWait) && (owner_q == OwnDma) && sd_rdvalid;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: per-cycle vector table plus
// hand-written sequences for arbitration order, starvation and ack hold-off.
module tb_sdram_port_arbiter;

    localparam logic [23:0] VgaAddr = 24'h001000;
    localparam logic [23:0] DmaAddr = 24'h002000;
    localparam logic [23:0] CpuAddr = 24'h000200;

    localparam logic [5:0] EReq  = 6'b100000;
    localparam logic [5:0] EVack = 6'b010000;
    localparam logic [5:0] ECack = 6'b000100;
    localparam logic [5:0] EVf   = 6'b000010;

    logic        clk = 1'b0;
    logic        reset;
    logic        vga_req, dma_req, cpu_req, cpu_wr;
    logic [23:0] vga_addr, dma_addr, cpu_addr;
    logic [15:0] cpu_wdata;
    logic [1:0]  cpu_bytesel;
    logic        vga_ack, vga_fill, dma_ack, dma_fill, cpu_ack;
    logic [15:0] cpu_rdata;
    logic        sd_req, sd_wr, sd_burst, sd_ack, sd_rdvalid;
    logic [23:0] sd_addr;
    logic [15:0] sd_wdata, sd_rdata;
    logic [1:0]  sd_bytesel;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sdram_port_arbiter #(
        .ADDR_W     (24),
        .BURST      (4),
        .CPU_STARVE (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .vga_req     (vga_req),
        .vga_addr    (vga_addr),
        .vga_ack     (vga_ack),
        .vga_fill    (vga_fill),
        .dma_req     (dma_req),
        .dma_addr    (dma_addr),
        .dma_ack     (dma_ack),
        .dma_fill    (dma_fill),
        .cpu_req     (cpu_req),
        .cpu_addr    (cpu_addr),
        .cpu_wr      (cpu_wr),
        .cpu_wdata   (cpu_wdata),
        .cpu_bytesel (cpu_bytesel),
        .cpu_ack     (cpu_ack),
        .cpu_rdata   (cpu_rdata),
        .sd_req      (sd_req),
        .sd_addr     (sd_addr),
        .sd_wr       (sd_wr),
        .sd_wdata    (sd_wdata),
        .sd_bytesel  (sd_bytesel),
        .sd_burst    (sd_burst),
        .sd_ack      (sd_ack),
        .sd_rdvalid  (sd_rdvalid),
        .sd_rdata    (sd_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst, vga, dma, cpu, wr, ack, rdv;
        logic [15:0] rdata;
        logic [5:0]  exp;   // {sd_req, vga_ack, dma_ack, cpu_ack, vga_fill, dma_fill}
        logic        attr;
        logic [23:0] e_addr;
        logic        e_wr;
        logic [15:0] e_wdata;
        logic [1:0]  e_bsel;
        logic        e_burst;
        string       name;
    } vec_t;

    vec_t tbl[$];
    logic [23:0] grants[$];
    logic [23:0] exp_grants[$];

    task automatic add(input logic rst, input logic vga, input logic dma, input logic cpu,
                       input logic wr, input logic ack, input logic rdv,
                       input logic [15:0] rdata, input logic [5:0] exp, input string name);
        vec_t v;
        v.rst = rst; v.vga = vga; v.dma = dma; v.cpu = cpu; v.wr = wr;
        v.ack = ack; v.rdv = rdv; v.rdata = rdata; v.exp = exp; v.name = name;
        v.attr = 1'b0; v.e_addr = '0; v.e_wr = 1'b0; v.e_wdata = '0;
        v.e_bsel = '0; v.e_burst = 1'b0;
        tbl.push_back(v);
    endtask

    task automatic add_a(input logic rst, input logic vga, input logic cpu, input logic wr,
                         input logic ack, input logic [5:0] exp, input string name,
                         input logic [23:0] e_addr, input logic e_wr,
                         input logic [15:0] e_wdata, input logic [1:0] e_bsel,
                         input logic e_burst);
        vec_t v;
        v.rst = rst; v.vga = vga; v.dma = 1'b0; v.cpu = cpu; v.wr = wr;
        v.ack = ack; v.rdv = 1'b0; v.rdata = '0; v.exp = exp; v.name = name;
        v.attr = 1'b1; v.e_addr = e_addr; v.e_wr = e_wr; v.e_wdata = e_wdata;
        v.e_bsel = e_bsel; v.e_burst = e_burst;
        tbl.push_back(v);
    endtask

    task automatic clear_inputs();
        vga_req = 1'b0; dma_req = 1'b0; cpu_req = 1'b0; cpu_wr = 1'b0;
        sd_ack = 1'b0; sd_rdvalid = 1'b0; sd_rdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Reactive controller + masters; records each grant by the address presented.
    task automatic run_engine(input bit dma_on, input bit cpu_on, input bit hold,
                              input int vga_at, input int want, input string tag);
        int          rd_left = 0;
        int          cyc = 0;
        int          n_vack = 0, n_dack = 0, n_cack = 0;
        int          e_v = 0, e_d = 0, e_c = 0;
        bit          drop_v = 0, drop_d = 0, drop_c = 0;
        logic [23:0] cur = '0;
        logic [15:0] word = 16'hC000;
        logic [15:0] cpu_exp = '0;
        grants.delete();
        vga_req = (vga_at == 0);
        dma_req = dma_on;
        cpu_req = cpu_on;
        cpu_wr  = 1'b0;
        while ((n_vack + n_dack + n_cack) < want && cyc < 400) begin
            if (drop_v) vga_req = 1'b0;
            if (drop_d && !hold) dma_req = 1'b0;
            if (drop_c && !hold) cpu_req = 1'b0;
            drop_v = 0; drop_d = 0; drop_c = 0;
            sd_ack = 1'b0;
            sd_rdvalid = 1'b0;
            if (rd_left > 0) begin
                sd_rdvalid = 1'b1;
                sd_rdata = word;
                if (cur == CpuAddr) cpu_exp = word;
                word++;
                rd_left--;
            end
            if (sd_req) begin
                sd_ack = 1'b1;
                cur = sd_addr;
                grants.push_back(sd_addr);
                if (!sd_wr) rd_left = sd_burst ? 4 : 1;
                if (vga_at > 0 && grants.size() == vga_at) vga_req = 1'b1;
            end
            #1;
            chk({tag, " vga_fill"}, 32'(vga_fill), 32'(sd_rdvalid && cur == VgaAddr));
            chk({tag, " dma_fill"}, 32'(dma_fill), 32'(sd_rdvalid && cur == DmaAddr));
            if (vga_ack) begin n_vack++; drop_v = 1; end
            if (dma_ack) begin n_dack++; drop_d = 1; end
            if (cpu_ack) begin
                n_cack++; drop_c = 1;
                chk({tag, " cpu_rdata"}, 32'(cpu_rdata), 32'(cpu_exp));
            end
            @(posedge clk); #1;
            cyc++;
        end
        clear_inputs();
        chk({tag, " grant_count"}, 32'(grants.size()), 32'(exp_grants.size()));
        for (int i = 0; i < exp_grants.size(); i++) begin
            chk($sformatf("%s grant_%0d", tag, i),
                32'((i < grants.size()) ? grants[i] : 24'hxxxxxx), 32'(exp_grants[i]));
            if (exp_grants[i] == VgaAddr) e_v++;
            if (exp_grants[i] == DmaAddr) e_d++;
            if (exp_grants[i] == CpuAddr) e_c++;
        end
        chk({tag, " vga_acks"}, 32'(n_vack), 32'(e_v));
        chk({tag, " dma_acks"}, 32'(n_dack), 32'(e_d));
        chk({tag, " cpu_acks"}, 32'(n_cack), 32'(e_c));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, expected to finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vga_addr = VgaAddr; dma_addr = DmaAddr; cpu_addr = CpuAddr;
        cpu_wdata = 16'hBEEF; cpu_bytesel = 2'b01;
        clear_inputs();
        reset = 1'b1;

        // VGA burst: sd_ack at 3, words at 5..8, ack at 9; stray strobes ignored.
        add_a(0, 1, 0, 0, 0, 6'b0, "reset_state", 24'h0, 0, 16'h0, 2'b00, 0);
        add_a(0, 1, 0, 0, 0, EReq, "vga_req_c1", VgaAddr, 0, 16'h0, 2'b11, 1);
        add(0, 1, 0, 0, 0, 0, 1, 16'hDEAD, EReq, "vga_stray_rdv_in_req");
        add(0, 1, 0, 0, 0, 1, 0, 16'h0, EReq, "vga_sd_ack_c3");
        add(0, 1, 0, 0, 0, 0, 0, 16'h0, 6'b0, "vga_wait_c4");
        for (int i = 0; i < 4; i++) add(0, 1, 0, 0, 0, 0, 1, 16'h1000, EVf, "vga_fill");
        add(0, 1, 0, 0, 0, 0, 0, 16'h0, EVack, "vga_ack_c9");
        add(0, 0, 0, 0, 0, 1, 0, 16'h0, 6'b0, "idle_stray_ack");
        add(0, 0, 0, 0, 0, 0, 0, 16'h0, 6'b0, "idle_quiet");
        // CPU write with immediate sd_ack.
        add(0, 0, 0, 1, 1, 0, 0, 16'h0, 6'b0, "cpuwr_c0");
        add_a(0, 0, 1, 1, 1, EReq, "cpuwr_req_c1", CpuAddr, 1, 16'hBEEF, 2'b01, 0);
        add(0, 0, 0, 1, 1, 0, 0, 16'h0, ECack, "cpuwr_ack_c2");
        add(0, 0, 0, 0, 0, 0, 0, 16'h0, 6'b0, "cpuwr_idle");
        // Reset in WAIT after two of four words.
        add(0, 1, 0, 0, 0, 0, 0, 16'h0, 6'b0, "rst_seq_c0");
        add(0, 1, 0, 0, 0, 1, 0, 16'h0, EReq, "rst_seq_ack");
        add(0, 1, 0, 0, 0, 0, 1, 16'h1, EVf, "rst_seq_w0");
        add(0, 1, 0, 0, 0, 0, 1, 16'h2, EVf, "rst_seq_w1");
        add(1, 1, 0, 0, 0, 0, 0, 16'h0, 6'b0, "rst_asserted");
        add_a(0, 0, 0, 0, 0, 6'b0, "rst_outputs", 24'h0, 0, 16'h0, 2'b00, 0);
        add(0, 0, 0, 0, 0, 0, 1, 16'h3, 6'b0, "rst_stray_rdv");
        add(0, 0, 0, 0, 0, 0, 1, 16'h4, 6'b0, "rst_stray_rdv");
        add(0, 0, 0, 0, 0, 0, 0, 16'h0, 6'b0, "rst_no_ack");

        repeat (3) @(posedge clk);
        #1;
        foreach (tbl[i]) begin
            reset = tbl[i].rst; vga_req = tbl[i].vga; dma_req = tbl[i].dma;
            cpu_req = tbl[i].cpu; cpu_wr = tbl[i].wr; sd_ack = tbl[i].ack;
            sd_rdvalid = tbl[i].rdv; sd_rdata = tbl[i].rdata;
            #1;
            chk({tbl[i].name, " handshake"},
                32'({sd_req, vga_ack, dma_ack, cpu_ack, vga_fill, dma_fill}), 32'(tbl[i].exp));
            if (tbl[i].attr) begin
                chk({tbl[i].name, " sd_addr"}, 32'(sd_addr), 32'(tbl[i].e_addr));
                chk({tbl[i].name, " sd_wr"}, 32'(sd_wr), 32'(tbl[i].e_wr));
                chk({tbl[i].name, " sd_wdata"}, 32'(sd_wdata), 32'(tbl[i].e_wdata));
                chk({tbl[i].name, " sd_bytesel"}, 32'(sd_bytesel), 32'(tbl[i].e_bsel));
                chk({tbl[i].name, " sd_burst"}, 32'(sd_burst), 32'(tbl[i].e_burst));
                chk({tbl[i].name, " cpu_rdata"}, 32'(cpu_rdata), 32'h0);
            end
            @(posedge clk); #1;
        end

        // CPU read with sd_ack held off for 20 cycles.
        do_reset();
        cpu_bytesel = 2'b11;
        cpu_req = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 20; c++) begin
            chk("holdoff sd_req", 32'(sd_req), 32'h1);
            chk("holdoff sd_addr", 32'(sd_addr), 32'(CpuAddr));
            chk("holdoff cpu_ack", 32'(cpu_ack), 32'h0);
            @(posedge clk); #1;
        end
        sd_ack = 1'b1;
        chk("holdoff sd_wr", 32'(sd_wr), 32'h0);
        @(posedge clk); #1;
        sd_ack = 1'b0;
        sd_rdvalid = 1'b1;
        sd_rdata = 16'h1234;
        chk("holdoff sd_req_dropped", 32'(sd_req), 32'h0);
        @(posedge clk); #1;
        sd_rdvalid = 1'b0;
        chk("holdoff cpu_ack", 32'(cpu_ack), 32'h1);
        chk("holdoff cpu_rdata", 32'(cpu_rdata), 32'h1234);
        @(posedge clk); #1;
        cpu_req = 1'b0;
        chk("holdoff ack_one_cycle", 32'(cpu_ack), 32'h0);
        chk("holdoff rdata_hold", 32'(cpu_rdata), 32'h1234);

        // All three request together; one-shot masters.
        do_reset();
        exp_grants = '{VgaAddr, DmaAddr, CpuAddr};
        run_engine(1, 1, 0, 0, 3, "three_way");

        // DMA and CPU held; VGA inserted while the 4th grant is in progress.
        do_reset();
        exp_grants = '{DmaAddr, DmaAddr, CpuAddr, DmaAddr, VgaAddr, DmaAddr, CpuAddr, DmaAddr};
        run_engine(1, 1, 1, 4, 8, "starve");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
